control_sequencer: RTL and testbench

Six-T-state controller for the 8-bit bus CPU. It drives the load and output-enable strobes of the program counter, memory address register, RAM, instruction register, accumulator, B register, ALU and output register. Its accumulator strobes connect directly to the accumulator stage: la_n is active-low load and ea is active-high bus drive. It decodes the opcode nibble held in the instruction register and freezes the machine on HLT.

---
 rtl/control_sequencer.sv | 119 +++++++++++
 tb/tb_control_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Six-T-state controller for the 8-bit bus CPU: one-hot T-state ring plus
// combinational strobe decode of the current state and the IR opcode nibble.
module control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm_n,
  output logic       ce_n,
  output logic       li_n,
  output logic       ei_n,
  output logic       la_n,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb_n,
  output logic       lo_n,
  output logic [5:0] tstate,
  output logic       halted
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= T1;
      halted <= 1'b0;
    end else if (!halted) begin
      // HLT freezes the ring in T4 until the next reset
      if (state == T4 && opcode == OP_HLT) begin
        halted <= 1'b1;
      end else begin
        case (state)
          T1:      state <= T2;
          T2:      state <= T3;
          T3:      state <= T4;
          T4:      state <= T5;
          T5:      state <= T6;
          T6:      state <= T1;
          default: state <= T1;
        endcase
      end
    end
  end

  assign tstate = state;

  always_comb begin
    cp   = 1'b0;
    ep   = 1'b0;
    lm_n = 1'b1;
    ce_n = 1'b1;
    li_n = 1'b1;
    ei_n = 1'b1;
    la_n = 1'b1;
    ea   = 1'b0;
    su   = 1'b0;
    eu   = 1'b0;
    lb_n = 1'b1;
    lo_n = 1'b1;
    // Reset and halt both hold every strobe at its inactive level
    if (rst_n && !halted) begin
      case (state)
        T1: begin
          ep   = 1'b1;
          lm_n = 1'b0;
        end
        T2: cp = 1'b1;
        T3: begin
          ce_n = 1'b0;
          li_n = 1'b0;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ei_n = 1'b0;
            lm_n = 1'b0;
          end else if (opcode == OP_OUT) begin
            ea   = 1'b1;
            lo_n = 1'b0;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ce_n = 1'b0;
            la_n = 1'b0;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ce_n = 1'b0;
            lb_n = 1'b0;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu   = 1'b1;
            la_n = 1'b0;
            su   = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected state/strobes
// from a reference model are queued at drive time and checked at the falling edge.
module tb_control_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
  logic [5:0] tstate;
  logic       halted;

  control_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .cp     (cp),
    .ep     (ep),
    .lm_n   (lm_n),
    .ce_n   (ce_n),
    .li_n   (li_n),
    .ei_n   (ei_n),
    .la_n   (la_n),
    .ea     (ea),
    .su     (su),
    .eu     (eu),
    .lb_n   (lb_n),
    .lo_n   (lo_n),
    .tstate (tstate),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {cp,ep,lm_n,ce_n,li_n,ei_n,la_n,ea,su,eu,lb_n,lo_n}
  localparam logic [11:0] IDLE = 12'b0011_1110_0011;

  logic [11:0] ctrl;
  assign ctrl = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n};

  typedef struct {
    logic [5:0]  ts;
    logic        hl;
    logic [11:0] ct;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   m_t    = 1;
  bit   m_halt = 1'b0;

  function automatic logic [11:0] model_ctrl(int t, bit h, logic [3:0] op, bit rstn);
    logic c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_la, c_ea, c_su, c_eu, c_lb, c_lo;
    {c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_la, c_ea, c_su, c_eu, c_lb, c_lo} = IDLE;
    if (rstn && !h) begin
      if (t == 1) begin c_ep = 1'b1; c_lm = 1'b0; end
      if (t == 2) c_cp = 1'b1;
      if (t == 3) begin c_ce = 1'b0; c_li = 1'b0; end
      if (t == 4 && (op == 4'h0 || op == 4'h1 || op == 4'h2)) begin c_ei = 1'b0; c_lm = 1'b0; end
      if (t == 4 && op == 4'hE) begin c_ea = 1'b1; c_lo = 1'b0; end
      if (t == 5 && op == 4'h0) begin c_ce = 1'b0; c_la = 1'b0; end
      if (t == 5 && (op == 4'h1 || op == 4'h2)) begin c_ce = 1'b0; c_lb = 1'b0; end
      if (t == 6 && (op == 4'h1 || op == 4'h2)) begin
        c_eu = 1'b1; c_la = 1'b0; c_su = (op == 4'h2);
      end
    end
    return {c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_la, c_ea, c_su, c_eu, c_lb, c_lo};
  endfunction

  // One clock: drive inputs, queue expectation, check at negedge, advance model.
  task automatic cycle(input logic [3:0] op, input bit rstn, input string name);
    exp_t e, got;
    int   drivers;
    opcode = op;
    rst_n  = rstn;
    e.ts = 6'b1 << (m_t - 1);
    e.hl = m_halt;
    e.ct = model_ctrl(m_t, m_halt, op, rstn);
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    checks++;
    if (tstate !== got.ts) begin
      errors++;
      $display("FAIL %s tstate: got %b want %b", name, tstate, got.ts);
    end
    checks++;
    if (halted !== got.hl) begin
      errors++;
      $display("FAIL %s halted: got %b want %b", name, halted, got.hl);
    end
    checks++;
    if (ctrl !== got.ct) begin
      errors++;
      $display("FAIL %s ctrl: got %b want %b", name, ctrl, got.ct);
    end
    drivers = int'(ep) + int'(!ce_n) + int'(!ei_n) + int'(ea) + int'(eu);
    checks++;
    if (drivers > 1) begin
      errors++;
      $display("FAIL %s bus_drivers: got %0d want <=1", name, drivers);
    end
    checks++;
    if (!la_n && ea) begin
      errors++;
      $display("FAIL %s la_ea_conflict: got la_n=0 ea=1 want not both", name);
    end
    @(posedge clk);
    #1;
    if (!rstn) begin
      m_t = 1;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_t == 4 && op == 4'hF) m_halt = 1'b1;
      else m_t = (m_t % 6) + 1;
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input string name);
    for (int i = 0; i < 6; i++) cycle(op, 1'b1, name);
  endtask

  task automatic test_reset();
    cycle(4'h1, 1'b0, "reset_hold0");
    cycle(4'h1, 1'b0, "reset_hold1");
    cycle(4'h1, 1'b1, "reset_release_t1");
    for (int i = 0; i < 5; i++) cycle(4'h1, 1'b1, "reset_finish_instr");
  endtask

  task automatic test_lda();
    run_instr(4'h0, "lda");
    cycle(4'h0, 1'b1, "lda_wrap_t1");
    for (int i = 0; i < 5; i++) cycle(4'h0, 1'b1, "lda_second");
  endtask

  task automatic test_add_sub();
    run_instr(4'h1, "add");
    run_instr(4'h2, "sub");
  endtask

  task automatic test_nop();
    run_instr(4'h5, "nop5");
  endtask

  task automatic test_out_hlt();
    run_instr(4'hE, "out");
    for (int i = 0; i < 4; i++) cycle(4'hF, 1'b1, "hlt_fetch");
    for (int i = 0; i < 20; i++) cycle(4'($urandom_range(0, 15)), 1'b1, "halted_hold");
    cycle(4'h0, 1'b0, "hlt_reset_pulse");
    run_instr(4'h0, "after_halt");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(4'h1, 1'b1, "mid_add_t1_t4");
    cycle(4'h1, 1'b0, "mid_reset_t5");
    cycle(4'h1, 1'b1, "mid_next_t1");
    for (int i = 0; i < 5; i++) cycle(4'h1, 1'b1, "mid_finish");
  endtask

  task automatic test_random();
    logic [3:0] ops [5] = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h5};
    logic [3:0] cur;
    cur = 4'h5;
    for (int i = 0; i < 1000; i++) begin
      if (m_t == 1) cur = ops[$urandom_range(0, 4)];
      // fetch states see junk on the opcode lines
      if (m_t <= 3) cycle(4'($urandom_range(0, 14)), 1'b1, "random_fetch");
      else cycle(cur, 1'b1, "random_exec");
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 4'h0;
    @(posedge clk);
    #1;
    m_t = 1;
    m_halt = 1'b0;
    test_reset();
    test_lda();
    test_add_sub();
    test_nop();
    test_out_hlt();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
